// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, sign fixed up at the end.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(ITER - 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             is_signed_q, is_signed_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        state_d     = state_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        a_abs      = (is_signed_q && a_q[WIDTH-1]) ? (-a_q) : a_q;
        b_abs      = (is_signed_q && b_q[WIDTH-1]) ? (-b_q) : b_q;
        mul_addend = acc_lo_q[0] ? b_q : '0;
        mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
        // Remainder is always below the divisor, so the top bit flags a negative trial.
        div_trial  = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, b_q};
        product    = {acc_hi_q, acc_lo_q};
        prod_fix   = neg_res_q ? (-product) : product;
        quo_fix    = neg_res_q ? (-acc_lo_q) : acc_lo_q;
        rem_fix    = neg_rem_q ? (-acc_hi_q) : acc_hi_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMthi: hi_d = a;
                        OpMtlo: lo_d = a;
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            a_d         = a;
                            b_d         = b;
                            is_div_d    = op[1];
                            is_signed_d = ~op[0];
                            state_d     = StPrep;
                        end
                        default: ;
                    endcase
                end
            end
            StPrep: begin
                acc_hi_d  = '0;
                acc_lo_d  = a_abs;
                b_d       = b_abs;
                neg_res_d = is_signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed_q && a_q[WIDTH-1];
                cnt_d     = CntInit;
                dbz_d     = is_div_q && (b_q == '0);
                state_d   = (is_div_q && (b_q == '0)) ? StFix : StCalc;
            end
            StCalc: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH]) begin
                        acc_hi_d = div_trial[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dbz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including MTHI/MTLO and the final write.
        if (flush) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StFix) && !flush;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised bench for muldiv_sequencer: stimulus pushes expected HI/LO and done cycle,
// a negedge monitor pops on every done pulse and compares.
module tb_muldiv_sequencer;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer #(
        .WIDTH (32),
        .ITER  (ITER)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference results straight from MIPS arithmetic rules, returned as {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin
                p = 64'(sx * sy);
                return p;
            end
            3'd1: return ux * uy;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                return {32'((ux % uy)), 32'((ux / uy))};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int exp_fall);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("busy_fall_cycle", 64'(cyc), 64'(exp_fall));
    endtask

    // Full mul/div transaction with scoreboard entry; optionally pokes start mid-flight.
    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inject);
        logic [63:0] r;
        exp_t        e;
        int          k;
        int          lat;
        r     = ref_model(o, x, y);
        lat   = (o[1] && y == 32'd0) ? 2 : ITER + 2;
        k     = cyc;
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.cyc = k + lat;
        exp_q.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_rise", 64'(busy), 64'd1);
        if (inject && lat > 6) begin
            repeat (3) step();
            start = 1'b1;
            op    = 3'b100;
            a     = 32'hCAFE_0000 | 32'($urandom_range(0, 255));
            step();
            start = 1'b0;
        end
        wait_idle(k + lat + 1);
        model_hi = r[63:32];
        model_lo = r[31:0];
    endtask

    task automatic run_mt(input bit is_lo, input logic [31:0] x);
        start = 1'b1;
        op    = is_lo ? 3'b101 : 3'b100;
        a     = x;
        step();
        start = 1'b0;
        if (is_lo) model_lo = x;
        else model_hi = x;
        chk(is_lo ? "mtlo_lo" : "mthi_hi", is_lo ? 64'(lo) : 64'(hi), 64'(x));
        chk("mt_busy", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 15));
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops on done, checks done timing, then HI/LO one cycle later.
    bit   pend = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("result_hi", 64'(hi), 64'(cur.hi));
                chk("result_lo", 64'(lo), 64'(cur.lo));
                pend = 1'b0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(cur.cyc));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [2:0]  o;
        logic [31:0] x, y;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        step();

        run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_md(3'd3, 32'd5, 32'd0, 1'b0);
        run_md(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);

        run_mt(1'b0, 32'h1234_5678);
        run_mt(1'b1, 32'h9ABC_DEF0);

        // start during a busy MULT is ignored
        run_md(3'd0, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);

        // reserved opcode
        start = 1'b1;
        op    = 3'b110;
        a     = 32'h5555_AAAA;
        step();
        start = 1'b0;
        chk("reserved_busy", 64'(busy), 64'd0);
        chk("reserved_hi", 64'(hi), 64'(model_hi));

        // flush mid-MULT: abort, HI/LO untouched, no done
        k     = cyc;
        start = 1'b1;
        op    = 3'b000;
        a     = 32'h0000_0007;
        b     = 32'h0000_0009;
        step();
        start = 1'b0;
        while (cyc < k + 10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'(model_hi));
        chk("flush_lo", 64'(lo), 64'(model_lo));
        repeat (40) step();
        chk("flush_hi_later", 64'(hi), 64'(model_hi));

        // flush arriving in the write-back cycle
        k     = cyc;
        start = 1'b1;
        op    = 3'b011;
        a     = 32'd100;
        b     = 32'd7;
        step();
        start = 1'b0;
        while (cyc < k + ITER + 2) step();
        chk("fix_busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        chk("fix_flush_done", 64'(done), 64'd0);
        step();
        flush = 1'b0;
        chk("fix_flush_busy", 64'(busy), 64'd0);
        chk("fix_flush_lo", 64'(lo), 64'(model_lo));

        // flush suppresses MTHI in IDLE
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b100;
        a     = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_mthi_hi", 64'(hi), 64'(model_hi));

        // synchronous reset in the middle of a DIV
        k     = cyc;
        start = 1'b1;
        op    = 3'b010;
        a     = 32'h7654_3210;
        b     = 32'd13;
        step();
        start = 1'b0;
        while (cyc < k + 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        step();

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            x = rnd_val();
            y = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd_val();
            if (o[2]) run_mt(o[0], x);
            else run_md(o, x, y, ($urandom_range(0, 3) == 0));
        end

        repeat (3) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("final_hi", 64'(hi), 64'(model_hi));
        chk("final_lo", 64'(lo), 64'(model_lo));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit and HI/LO register file for the 5-stage pipeline.
- Sits beside the single-cycle ALU in EX and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Raises a stall to the hazard logic while an operation is in flight.
- Exposes HI/LO continuously for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, CALC-state iterations; must equal WIDTH (radix-2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request from EX; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  pipeline flush; aborts any operation.
- busy  out  1  high whenever state != IDLE; drives pipeline stall.
- done  out  1  one-cycle pulse in the cycle HI/LO are written by mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, internal accumulators=0. Reset mid-operation aborts it and zeroes HI/LO.
- States: IDLE, PREP, CALC, FIX.
- IDLE, start=1, op=MTHI/MTLO: HI (or LO) <= a at that clock edge. Value is visible next cycle. State stays IDLE and busy stays 0.
- IDLE, start=1, op=mul/div: latch a, b, op; go to PREP.
- PREP (1 cycle):
  - Take absolute values for signed ops; record result sign and dividend sign.
  - Init counter=ITER-1.
  - Divide with b==0: go directly to FIX with the div-by-zero result.
  - Otherwise go to CALC.
- CALC (ITER cycles):
  - Multiply is shift-add, one multiplier bit per cycle, into a 2*WIDTH product.
  - Divide is restoring, one quotient bit per cycle.
  - Counter decrements each cycle; go to FIX when counter==0.
- FIX (1 cycle):
  - Apply sign correction, write HI/LO, assert done, return to IDLE.
  - For multiply: HI=product[63:32], LO=product[31:0].
  - For divide: LO=quotient, HI=remainder.
- Latency: start at edge T. busy=1 from T+1 through FIX. Normal ops: FIX at cycle T+ITER+2, new HI/LO visible at T+ITER+3, busy low at T+ITER+3. Div-by-zero: FIX at T+2.
- Signed divide rounding: quotient truncates toward zero; remainder takes the dividend's sign.
- Signed divide overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=a.
- start while busy: ignored. The pipeline must hold the request, since stall is active.
- flush:
  - In any state, next state is IDLE and done=0.
  - HI/LO keep their pre-operation values.
  - flush has priority over start and over the FIX write in the same cycle.
  - flush in IDLE with start=1 and MTHI/MTLO: the write is suppressed.
- Reserved op with start: ignored, no state change.
- done is never asserted except in FIX.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; done at T+34; busy high T+1..T+34.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5, done at T+2.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0. Second start issued during a busy MULT is ignored and the MULT result is unaffected.
- MULT started, flush at T+10 -> busy=0 at T+11, HI/LO unchanged, no done. Separately, rst at T+20 of a DIV -> HI=LO=0, IDLE next cycle.
